// File: rtl/frame_path_scheduler.sv
// Frame scheduler: one meta header beat per frame, then payload packets alternating in1/in2 per group.
// Optional SCHED_STATS_EN adds saturating frame/stall counters (stat_frames, stat_stalls).
module frame_path_scheduler #(
    parameter int DW                = 128,
    parameter int PACKET_BEATS      = 2,
    parameter int PACKETS_PER_FRAME = 128,
    parameter int PP_GROUP          = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [DW-1:0]   in1_tdata,
    input  logic            in1_tvalid,
    output logic            in1_tready,
    input  logic [DW-1:0]   in2_tdata,
    input  logic            in2_tvalid,
    output logic            in2_tready,
    input  logic [DW-1:0]   meta_tdata,
    input  logic            meta_tvalid,
    output logic            meta_tready,
    output logic [DW-1:0]   out_tdata,
    output logic            out_tvalid,
    input  logic            out_tready,
    output logic            out_tlast,
    output logic [DW/8-1:0] out_tkeep,
    output logic            out_hdr,
    output logic            out_src
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]     stat_frames,
    output logic [31:0]     stat_stalls
`endif
);

    localparam int BW = $clog2(PACKET_BEATS + 1);
    localparam int PW = $clog2(PACKETS_PER_FRAME + 1);
    localparam int GW = $clog2(PP_GROUP + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(PACKET_BEATS - 1);
    localparam logic [PW-1:0] PKT_LAST  = PW'(PACKETS_PER_FRAME - 1);
    localparam logic [GW-1:0] GRP_LAST  = GW'(PP_GROUP - 1);

    typedef enum logic {HDR, PKT} state_t;

    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic [PW-1:0] pkt_cnt;
    logic [GW-1:0] grp_cnt;
    logic          grant;

    logic          adv, meta_hs, pay_hs, pkt_end, frame_end;
    logic [DW-1:0] pay_data;

    assign adv = !out_tvalid || out_tready;

    // Ready is held low during reset so no source sees a handshake that the FSM would discard.
    assign meta_tready = resetn && (state == HDR) && adv;
    assign in1_tready  = resetn && (state == PKT) && !grant && adv;
    assign in2_tready  = resetn && (state == PKT) &&  grant && adv;

    assign meta_hs   = meta_tvalid && meta_tready;
    assign pay_hs    = (in1_tvalid && in1_tready) || (in2_tvalid && in2_tready);
    assign pay_data  = grant ? in2_tdata : in1_tdata;
    assign pkt_end   = pay_hs && (beat_cnt == BEAT_LAST);
    assign frame_end = pkt_end && (pkt_cnt == PKT_LAST);
    assign out_tkeep = {(DW/8){out_tvalid}};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= HDR;
            beat_cnt   <= '0;
            pkt_cnt    <= '0;
            grp_cnt    <= '0;
            grant      <= 1'b0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            out_hdr    <= 1'b0;
            out_src    <= 1'b0;
        end else begin
            if (adv) begin
                out_tvalid <= meta_hs || pay_hs;
                if (meta_hs) begin
                    out_tdata <= meta_tdata;
                    out_tlast <= 1'b0;
                    out_hdr   <= 1'b1;
                    out_src   <= 1'b0;
                end else if (pay_hs) begin
                    out_tdata <= pay_data;
                    out_tlast <= pkt_end;
                    out_hdr   <= 1'b0;
                    out_src   <= grant;
                end
            end
            if (meta_hs)
                state <= PKT;
            if (pay_hs) begin
                if (pkt_end) begin
                    beat_cnt <= '0;
                    if (frame_end) begin
                        pkt_cnt <= '0;
                        grp_cnt <= '0;
                        grant   <= 1'b0;
                        state   <= HDR;
                    end else begin
                        pkt_cnt <= pkt_cnt + 1'b1;
                        if (grp_cnt == GRP_LAST) begin
                            grp_cnt <= '0;
                            grant   <= ~grant;
                        end else begin
                            grp_cnt <= grp_cnt + 1'b1;
                        end
                    end
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_frames <= '0;
            stat_stalls <= '0;
        end else begin
            if (frame_end && stat_frames != 32'hFFFF_FFFF)
                stat_frames <= stat_frames + 1'b1;
            if (out_tvalid && !out_tready && stat_stalls != 32'hFFFF_FFFF)
                stat_stalls <= stat_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_path_scheduler.sv
// Directed table-driven bench for frame_path_scheduler (PACKET_BEATS=2, PACKETS_PER_FRAME=4, PP_GROUP=2).
module tb_frame_path_scheduler;

    localparam int DW = 128;

    logic            clk, resetn;
    logic [DW-1:0]   in1_tdata, in2_tdata, meta_tdata, out_tdata;
    logic            in1_tvalid, in1_tready, in2_tvalid, in2_tready;
    logic            meta_tvalid, meta_tready;
    logic            out_tvalid, out_tready, out_tlast, out_hdr, out_src;
    logic [DW/8-1:0] out_tkeep;
`ifdef SCHED_STATS_EN
    logic [31:0]     stat_frames, stat_stalls;
`endif

    frame_path_scheduler #(
        .DW(DW), .PACKET_BEATS(2), .PACKETS_PER_FRAME(4), .PP_GROUP(2)
    ) dut (
        .clk(clk), .resetn(resetn),
        .in1_tdata(in1_tdata), .in1_tvalid(in1_tvalid), .in1_tready(in1_tready),
        .in2_tdata(in2_tdata), .in2_tvalid(in2_tvalid), .in2_tready(in2_tready),
        .meta_tdata(meta_tdata), .meta_tvalid(meta_tvalid), .meta_tready(meta_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tlast(out_tlast), .out_tkeep(out_tkeep), .out_hdr(out_hdr), .out_src(out_src)
`ifdef SCHED_STATS_EN
        , .stat_frames(stat_frames), .stat_stalls(stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy, v1, v2, vm;
        logic       r1, r2, rm;
        logic       vld;
        logic [7:0] tag;
        logic       last, hdr, src;
    } vec_t;

    vec_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   a_idx = 0, b_idx = 0, m_idx = 0;

    function automatic vec_t mk(input logic rdy, v1, v2, vm, r1, r2, rm, vld,
                                input logic [7:0] tag, input logic last, hdr, src);
        vec_t r;
        r.rdy = rdy; r.v1 = v1; r.v2 = v2; r.vm = vm;
        r.r1 = r1; r.r2 = r2; r.rm = rm; r.vld = vld;
        r.tag = tag; r.last = last; r.hdr = hdr; r.src = src;
        return r;
    endfunction

    task automatic chk(input string nm, input int n, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d act=%h exp=%h", nm, n, act, exp);
        end
    endtask

    task automatic drive_data();
        logic [7:0] t;
        t = 8'hA0 + 8'(a_idx); in1_tdata  = {16{t}};
        t = 8'hB0 + 8'(b_idx); in2_tdata  = {16{t}};
        t = 8'h10 + 8'(m_idx); meta_tdata = {16{t}};
    endtask

    task automatic run_row(input vec_t r, input int n);
        logic h1, h2, hm;
        out_tready = r.rdy; in1_tvalid = r.v1; in2_tvalid = r.v2; meta_tvalid = r.vm;
        drive_data();
        @(negedge clk);
        chk("in1_tready", n, 128'(in1_tready), 128'(r.r1));
        chk("in2_tready", n, 128'(in2_tready), 128'(r.r2));
        chk("meta_tready", n, 128'(meta_tready), 128'(r.rm));
        h1 = in1_tvalid && in1_tready;
        h2 = in2_tvalid && in2_tready;
        hm = meta_tvalid && meta_tready;
        @(posedge clk); #1;
        if (h1) a_idx++;
        if (h2) b_idx++;
        if (hm) m_idx++;
        chk("out_tvalid", n, 128'(out_tvalid), 128'(r.vld));
        chk("out_tkeep", n, 128'(out_tkeep), 128'({16{r.vld}}));
        if (r.vld) begin
            chk("out_tdata", n, out_tdata, {16{r.tag}});
            chk("out_tlast", n, 128'(out_tlast), 128'(r.last));
            chk("out_hdr", n, 128'(out_hdr), 128'(r.hdr));
            chk("out_src", n, 128'(out_src), 128'(r.src));
        end
    endtask

    initial begin
        logic [7:0] tg, ptg;
        logic       pl, ps;

        // Frame 1: everything valid, output always ready.
        q.push_back(mk(1,1,1,1, 0,0,1, 1, 8'h10, 0,1,0));
        for (int k = 0; k < 8; k++) begin
            tg = (k < 4) ? 8'hA0 + 8'(k) : 8'hB0 + 8'(k - 4);
            q.push_back(mk(1,1,1,1, k < 4, k >= 4, 0, 1, tg, k % 2 == 1, 0, k >= 4));
        end
        // Frame 2: out_tready alternates, each beat must hold while stalled.
        q.push_back(mk(1,1,1,1, 0,0,1, 1, 8'h11, 0,1,0));
        ptg = 8'h11; pl = 1'b0; ps = 1'b0;
        for (int k = 0; k < 8; k++) begin
            q.push_back(mk(0,1,1,1, 0,0,0, 1, ptg, pl, ptg == 8'h11, ps));
            tg = (k < 4) ? 8'hA4 + 8'(k) : 8'hB4 + 8'(k - 4);
            q.push_back(mk(1,1,1,1, k < 4, k >= 4, 0, 1, tg, k % 2 == 1, 0, k >= 4));
            ptg = tg; pl = (k % 2 == 1); ps = (k >= 4);
        end
        q.push_back(mk(0,1,1,1, 0,0,0, 1, 8'hB7, 1,0,1));
        q.push_back(mk(1,1,1,1, 0,0,1, 1, 8'h12, 0,1,0));
        // Frame 3: in1 goes idle for 5 cycles after A8; in2 must not be granted.
        q.push_back(mk(1,1,1,1, 1,0,0, 1, 8'hA8, 0,0,0));
        for (int k = 0; k < 5; k++)
            q.push_back(mk(1,0,1,1, 1,0,0, 0, 8'h00, 0,0,0));
        q.push_back(mk(1,1,1,1, 1,0,0, 1, 8'hA9, 1,0,0));
        q.push_back(mk(1,1,1,1, 1,0,0, 1, 8'hAA, 0,0,0));
        q.push_back(mk(1,1,1,1, 1,0,0, 1, 8'hAB, 1,0,0));
        for (int k = 0; k < 4; k++)
            q.push_back(mk(1,1,1,1, 0,1,0, 1, 8'hB8 + 8'(k), k % 2 == 1, 0, 1));
        // Frame boundary: meta absent for 10 cycles stalls all payload.
        for (int k = 0; k < 10; k++)
            q.push_back(mk(1,1,1,0, 0,0,1, 0, 8'h00, 0,0,0));
        q.push_back(mk(1,1,1,1, 0,0,1, 1, 8'h13, 0,1,0));
        q.push_back(mk(1,1,1,1, 1,0,0, 1, 8'hAC, 0,0,0));

        resetn = 1'b0; out_tready = 1'b1;
        in1_tvalid = 1'b1; in2_tvalid = 1'b1; meta_tvalid = 1'b1;
        drive_data();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_meta_tready", -1, 128'(meta_tready), 128'(0));
        chk("rst_in1_tready", -1, 128'(in1_tready), 128'(0));
        chk("rst_out_tvalid", -1, 128'(out_tvalid), 128'(0));
        chk("rst_out_tkeep", -1, 128'(out_tkeep), 128'(0));
        chk("rst_out_tdata", -1, out_tdata, 128'(0));
`ifdef SCHED_STATS_EN
        chk("rst_stat_frames", -1, 128'(stat_frames), 128'(0));
        chk("rst_stat_stalls", -1, 128'(stat_stalls), 128'(0));
`endif
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < q.size(); i++) begin
            run_row(q[i], i);
`ifdef SCHED_STATS_EN
            if (i == 27) begin
                chk("stat_frames", i, 128'(stat_frames), 128'(2));
                chk("stat_stalls", i, 128'(stat_stalls), 128'(9));
            end
`endif
        end

        // Reset right after A12 is accepted: partial packet dropped, next output is a header.
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_meta_tready", 900, 128'(meta_tready), 128'(0));
        chk("mid_rst_in1_tready", 900, 128'(in1_tready), 128'(0));
        @(posedge clk); #1;
        chk("mid_rst_out_tvalid", 901, 128'(out_tvalid), 128'(0));
        chk("mid_rst_out_tdata", 901, out_tdata, 128'(0));
        chk("mid_rst_out_tlast", 901, 128'(out_tlast), 128'(0));
        chk("mid_rst_out_hdr", 901, 128'(out_hdr), 128'(0));
        chk("mid_rst_out_src", 901, 128'(out_src), 128'(0));
        chk("mid_rst_out_tkeep", 901, 128'(out_tkeep), 128'(0));
        resetn = 1'b1;
        run_row(mk(1,1,1,1, 0,0,1, 1, 8'h14, 0,1,0), 902);
        run_row(mk(1,1,1,1, 1,0,0, 1, 8'hAD, 0,0,0), 903);
        run_row(mk(1,1,1,1, 1,0,0, 1, 8'hAE, 1,0,0), 904);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
